// File: rtl/mem_ring_requester_if.sv
// Client-side request/response bundle for mem_ring_requester.
// master = local client (core/cache), slave = ring requester.
interface mem_ring_requester_if;
    logic         reqValid;
    logic         reqReady;
    logic         reqRead;
    logic [25:0]  reqAddr;
    logic [127:0] reqWData;
    logic         rdValid;
    logic [127:0] rdData;

    modport master (
        output reqValid, reqRead, reqAddr, reqWData,
        input  reqReady, rdValid, rdData
    );

    modport slave (
        input  reqValid, reqRead, reqAddr, reqWData,
        output reqReady, rdValid, rdData
    );
endinterface

// File: rtl/mem_ring_requester.sv
// Memory ring initiator: one line request at a time onto the ring, read lines reassembled from RDreturn.
// Optional read-return watchdog enabled by defining MRR_TIMEOUT_EN.
module mem_ring_requester #(
    parameter logic [3:0]  MY_ID           = 4'd1,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 RingIn,
    input  logic [3:0]                  SlotTypeIn,
    input  logic [3:0]                  SourceIn,
    output logic [31:0]                 RingOut,
    output logic [3:0]                  SlotTypeOut,
    output logic [3:0]                  SourceOut,
    input  logic [31:0]                 RDreturn,
    input  logic [3:0]                  RDdest,
    mem_ring_requester_if.slave         req_if,
    output logic                        protoErr,
    output logic                        rdTimeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PEND   = 2'd1;
    localparam logic [1:0] S_WDATA  = 2'd2;
    localparam logic [1:0] S_TOKOUT = 2'd3;

    localparam logic [3:0] SLOT_NULL      = 4'h0;
    localparam logic [3:0] SLOT_TOKEN     = 4'h1;
    localparam logic [3:0] SLOT_ADDRESS   = 4'h2;
    localparam logic [3:0] SLOT_WRITEDATA = 4'h3;

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    if (MY_ID == 4'd0 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("mem_ring_requester: illegal parameter value");
    end

    logic [1:0]   state_q, state_d;
    logic         hold_read_q, hold_read_d;
    logic [25:0]  hold_addr_q, hold_addr_d;
    logic [127:0] hold_wdata_q, hold_wdata_d;
    logic [1:0]   wcnt_q, wcnt_d;
    logic [3:0]   outst_q, outst_d;
    logic [1:0]   rcnt_q, rcnt_d;
    logic [95:0]  rbuf_q, rbuf_d;
    logic         rd_valid_q, rd_valid_d;
    logic [127:0] rd_data_q, rd_data_d;
    logic         proto_err_q, proto_err_d;

    logic         rd_match;
    logic         issue_read;
    logic         line_done;
    logic [31:0]  addr_word;
    logic [31:0]  wword;

    assign rd_match  = (RDdest == MY_ID);
    assign addr_word = {3'b000, hold_read_q, 2'b00, hold_addr_q};

    always_comb begin
        case (wcnt_q)
            2'd0:    wword = hold_wdata_q[31:0];
            2'd1:    wword = hold_wdata_q[63:32];
            2'd2:    wword = hold_wdata_q[95:64];
            default: wword = hold_wdata_q[127:96];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        hold_read_d  = hold_read_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        wcnt_d       = wcnt_q;
        outst_d      = outst_q;
        rcnt_d       = rcnt_q;
        rbuf_d       = rbuf_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        proto_err_d  = proto_err_q;
        issue_read   = 1'b0;
        line_done    = 1'b0;
        SlotTypeOut  = SlotTypeIn;
        RingOut      = RingIn;
        SourceOut    = SourceIn;

        case (state_q)
            S_IDLE: begin
                if (req_if.reqValid) begin
                    hold_read_d  = req_if.reqRead;
                    hold_addr_d  = req_if.reqAddr;
                    hold_wdata_d = req_if.reqWData;
                    state_d      = S_PEND;
                end
            end
            S_PEND: begin
                // A read blocked by the outstanding limit lets the token pass untouched.
                if (SlotTypeIn == SLOT_TOKEN && (!hold_read_q || outst_q < MAX_OUT)) begin
                    SlotTypeOut = SLOT_ADDRESS;
                    RingOut     = addr_word;
                    SourceOut   = MY_ID;
                    issue_read  = hold_read_q;
                    wcnt_d      = 2'd0;
                    state_d     = hold_read_q ? S_TOKOUT : S_WDATA;
                end
            end
            S_WDATA: begin
                SlotTypeOut = SLOT_WRITEDATA;
                RingOut     = wword;
                SourceOut   = MY_ID;
                wcnt_d      = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) state_d = S_TOKOUT;
                if (SlotTypeIn != SLOT_NULL) proto_err_d = 1'b1;
            end
            default: begin
                SlotTypeOut = SLOT_TOKEN;
                RingOut     = '0;
                SourceOut   = '0;
                state_d     = S_IDLE;
                if (SlotTypeIn != SLOT_NULL) proto_err_d = 1'b1;
            end
        endcase

        if (rd_match) begin
            if (outst_q == 4'd0) begin
                proto_err_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 2'd1;
                case (rcnt_q)
                    2'd0: rbuf_d[31:0]  = RDreturn;
                    2'd1: rbuf_d[63:32] = RDreturn;
                    2'd2: rbuf_d[95:64] = RDreturn;
                    default: begin
                        line_done  = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_data_d  = {RDreturn, rbuf_q};
                    end
                endcase
            end
        end

        case ({issue_read, line_done})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase

        if (reset) begin
            SlotTypeOut = SLOT_NULL;
            RingOut     = '0;
            SourceOut   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_read_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            wcnt_q       <= '0;
            outst_q      <= '0;
            rcnt_q       <= '0;
            rbuf_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_read_q  <= hold_read_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            wcnt_q       <= wcnt_d;
            outst_q      <= outst_d;
            rcnt_q       <= rcnt_d;
            rbuf_q       <= rbuf_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign req_if.reqReady = (state_q == S_IDLE) && !reset;
    assign req_if.rdValid  = rd_valid_q;
    assign req_if.rdData   = rd_data_q;
    assign protoErr        = proto_err_q;

`ifdef MRR_TIMEOUT_EN
    localparam logic [15:0] TLIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        rd_timeout_q, rd_timeout_d;

    // Counter saturates at the limit so the flag cannot be missed by wrapping.
    always_comb begin
        wd_cnt_d     = wd_cnt_q;
        rd_timeout_d = rd_timeout_q;
        if (outst_q == 4'd0 || rd_match) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != TLIMIT) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end
        if (wd_cnt_d == TLIMIT) rd_timeout_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q     <= '0;
            rd_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q     <= wd_cnt_d;
            rd_timeout_q <= rd_timeout_d;
        end
    end

    assign rdTimeout = rd_timeout_q;
`else
    assign rdTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ring_requester.sv
// Directed vector bench for mem_ring_requester (MY_ID=1, MAX_OUTSTANDING=2).
module tb_mem_ring_requester;

    localparam logic [3:0] NUL = 4'h0;
    localparam logic [3:0] TOK = 4'h1;
    localparam logic [3:0] ADR = 4'h2;
    localparam logic [3:0] WDS = 4'h3;
    localparam logic [127:0] W1 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] W2 = 128'h00000008_00000007_00000006_00000005;

    typedef struct {
        logic         rst;
        logic [3:0]   sti;
        logic [31:0]  ri;
        logic [3:0]   si;
        logic [3:0]   rdd;
        logic [31:0]  rdr;
        logic         rv;
        logic         rr;
        logic [25:0]  ra;
        logic [127:0] wd;
        logic [3:0]   e_sto;
        logic [31:0]  e_ro;
        logic [3:0]   e_so;
        logic         e_rdy;
        logic         e_rdv;
        logic         e_perr;
        logic [127:0] e_rdata;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ring_in = '0;
    logic [3:0]  slot_type_in = '0;
    logic [3:0]  source_in = '0;
    logic [31:0] ring_out;
    logic [3:0]  slot_type_out;
    logic [3:0]  source_out;
    logic [31:0] rd_return = '0;
    logic [3:0]  rd_dest = '0;
    logic        proto_err;
    logic        rd_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_ring_requester_if ifc ();

    mem_ring_requester #(
        .MY_ID(4'd1),
        .MAX_OUTSTANDING(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .RingIn(ring_in),
        .SlotTypeIn(slot_type_in),
        .SourceIn(source_in),
        .RingOut(ring_out),
        .SlotTypeOut(slot_type_out),
        .SourceOut(source_out),
        .RDreturn(rd_return),
        .RDdest(rd_dest),
        .req_if(ifc.slave),
        .protoErr(proto_err),
        .rdTimeout(rd_timeout)
    );

    function automatic vec_t r(logic rst, logic [3:0] sti, logic [31:0] ri, logic [3:0] si,
                               logic [3:0] rdd, logic [31:0] rdr,
                               logic [3:0] esto, logic [31:0] ero, logic [3:0] eso,
                               logic erdy, logic erdv, logic eperr);
        vec_t v;
        v.rst = rst; v.sti = sti; v.ri = ri; v.si = si; v.rdd = rdd; v.rdr = rdr;
        v.rv = 1'b0; v.rr = 1'b0; v.ra = '0; v.wd = '0;
        v.e_sto = esto; v.e_ro = ero; v.e_so = eso;
        v.e_rdy = erdy; v.e_rdv = erdv; v.e_perr = eperr; v.e_rdata = '0;
        return v;
    endfunction

    function automatic vec_t q(vec_t vin, logic rd, logic [25:0] addr, logic [127:0] wdata);
        vec_t v = vin;
        v.rv = 1'b1; v.rr = rd; v.ra = addr; v.wd = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(posedge clock);
        #1;
        reset        = t.rst;
        slot_type_in = t.sti;
        ring_in      = t.ri;
        source_in    = t.si;
        rd_dest      = t.rdd;
        rd_return    = t.rdr;
        ifc.reqValid = t.rv;
        ifc.reqRead  = t.rr;
        ifc.reqAddr  = t.ra;
        ifc.reqWData = t.wd;
        @(negedge clock);
        chk({tag, " ring"}, {88'b0, slot_type_out, ring_out, source_out},
            {88'b0, t.e_sto, t.e_ro, t.e_so});
        chk({tag, " reqReady"}, {127'b0, ifc.reqReady}, {127'b0, t.e_rdy});
        chk({tag, " rdValid"}, {127'b0, ifc.rdValid}, {127'b0, t.e_rdv});
        chk({tag, " protoErr/rdTimeout"}, {126'b0, proto_err, rd_timeout}, {126'b0, t.e_perr, 1'b0});
        if (t.e_rdv) chk({tag, " rdData"}, ifc.rdData, t.e_rdata);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[20];

        ifc.reqValid = 1'b0;
        ifc.reqRead  = 1'b0;
        ifc.reqAddr  = '0;
        ifc.reqWData = '0;
        repeat (3) @(posedge clock);

        // write line, then read line with interleaved foreign returns
        tbl[0]  = r(1'b1, ADR, 32'hDEADBEEF, 4'd5, 4'd0, '0, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = r(1'b0, WDS, 32'hCAFE0001, 4'd3, 4'd0, '0, WDS, 32'hCAFE0001, 4'd3, 1'b1, 1'b0, 1'b0);
        tbl[2]  = q(r(1'b0, TOK, '0, 4'd0, 4'd0, '0, TOK, '0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 26'h0000123, W1);
        tbl[3]  = r(1'b0, ADR, 32'h12345678, 4'd2, 4'd0, '0, ADR, 32'h12345678, 4'd2, 1'b0, 1'b0, 1'b0);
        tbl[4]  = r(1'b0, TOK, '0, 4'd0, 4'd0, '0, ADR, 32'h00000123, 4'd1, 1'b0, 1'b0, 1'b0);
        tbl[5]  = r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        tbl[6]  = r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd2, 4'd1, 1'b0, 1'b0, 1'b0);
        tbl[7]  = r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd3, 4'd1, 1'b0, 1'b0, 1'b0);
        tbl[8]  = r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd4, 4'd1, 1'b0, 1'b0, 1'b0);
        tbl[9]  = r(1'b0, NUL, '0, 4'd0, 4'd0, '0, TOK, '0, 4'd0, 1'b0, 1'b0, 1'b0);
        tbl[10] = q(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b1, 26'h3FFFFFF, '0);
        tbl[11] = r(1'b0, TOK, '0, 4'd7, 4'd0, '0, ADR, 32'h13FFFFFF, 4'd1, 1'b0, 1'b0, 1'b0);
        tbl[12] = r(1'b0, NUL, '0, 4'd0, 4'd1, 32'hAAAA0000, TOK, '0, 4'd0, 1'b0, 1'b0, 1'b0);
        tbl[13] = r(1'b0, WDS, 32'h77, 4'd6, 4'd5, 32'hBAD00005, WDS, 32'h77, 4'd6, 1'b1, 1'b0, 1'b0);
        tbl[14] = r(1'b0, NUL, '0, 4'd0, 4'd1, 32'hBBBB1111, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0);
        tbl[15] = r(1'b0, NUL, '0, 4'd0, 4'd1, 32'hCCCC2222, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0);
        tbl[16] = r(1'b0, NUL, '0, 4'd0, 4'd2, 32'hBAD00002, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0);
        tbl[17] = r(1'b0, NUL, '0, 4'd0, 4'd1, 32'hDDDD3333, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0);
        tbl[18] = r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b1, 1'b0);
        tbl[18].e_rdata = 128'hDDDD3333_CCCC2222_BBBB1111_AAAA0000;
        tbl[19] = r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // outstanding limit of 2: third read waits for a completed line
        apply(q(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b1, 26'h0000010, '0), "max r1 acc");
        apply(r(1'b0, TOK, '0, 4'd0, 4'd0, '0, ADR, 32'h10000010, 4'd1, 1'b0, 1'b0, 1'b0), "max r1 adr");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, TOK, '0, 4'd0, 1'b0, 1'b0, 1'b0), "max r1 tok");
        apply(q(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b1, 26'h0000020, '0), "max r2 acc");
        apply(r(1'b0, TOK, '0, 4'd0, 4'd0, '0, ADR, 32'h10000020, 4'd1, 1'b0, 1'b0, 1'b0), "max r2 adr");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, TOK, '0, 4'd0, 1'b0, 1'b0, 1'b0), "max r2 tok");
        apply(q(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b1, 26'h0000030, '0), "max r3 acc");
        apply(r(1'b0, TOK, 32'h55, 4'd9, 4'd0, '0, TOK, 32'h55, 4'd9, 1'b0, 1'b0, 1'b0), "max r3 hold1");
        apply(r(1'b0, TOK, 32'h66, 4'd3, 4'd0, '0, TOK, 32'h66, 4'd3, 1'b0, 1'b0, 1'b0), "max r3 hold2");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd1, 32'h11, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b0), "max ret0");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd1, 32'h22, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b0), "max ret1");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd1, 32'h33, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b0), "max ret2");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd1, 32'h44, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b0), "max ret3");
        begin
            vec_t v;
            v = r(1'b0, TOK, '0, 4'd0, 4'd0, '0, ADR, 32'h10000030, 4'd1, 1'b0, 1'b1, 1'b0);
            v.e_rdata = 128'h00000044_00000033_00000022_00000011;
            apply(v, "max r3 adr");
        end
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, TOK, '0, 4'd0, 1'b0, 1'b0, 1'b0), "max r3 tok");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), "max idle");

        // reset during write data word 2, then a stray return proves outstanding was cleared
        apply(q(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 26'h0000ABC, W2), "rst acc");
        apply(r(1'b0, TOK, '0, 4'd0, 4'd0, '0, ADR, 32'h00000ABC, 4'd1, 1'b0, 1'b0, 1'b0), "rst adr");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd5, 4'd1, 1'b0, 1'b0, 1'b0), "rst wd0");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd6, 4'd1, 1'b0, 1'b0, 1'b0), "rst wd1");
        apply(r(1'b1, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b0), "rst hi0");
        apply(r(1'b1, WDS, 32'h9, 4'd4, 4'd0, '0, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b0), "rst hi1");
        apply(r(1'b0, ADR, 32'h99, 4'd2, 4'd0, '0, ADR, 32'h99, 4'd2, 1'b1, 1'b0, 1'b0), "rst idle");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd1, 32'hF00D, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), "stray ret");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b1), "stray err");
        apply(r(1'b1, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b1), "clr rst");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), "clr idle");

        // Address slot injected during write data: dropped, sticky protoErr
        apply(q(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 26'h0000001, W1), "inj acc");
        apply(r(1'b0, TOK, '0, 4'd0, 4'd0, '0, ADR, 32'h00000001, 4'd1, 1'b0, 1'b0, 1'b0), "inj adr");
        apply(r(1'b0, ADR, 32'hBADBAD, 4'd3, 4'd0, '0, WDS, 32'd1, 4'd1, 1'b0, 1'b0, 1'b0), "inj wd0");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd2, 4'd1, 1'b0, 1'b0, 1'b1), "inj wd1");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd3, 4'd1, 1'b0, 1'b0, 1'b1), "inj wd2");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, WDS, 32'd4, 4'd1, 1'b0, 1'b0, 1'b1), "inj wd3");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, TOK, '0, 4'd0, 1'b0, 1'b0, 1'b1), "inj tok");
        apply(r(1'b0, WDS, 32'h42, 4'd7, 4'd0, '0, WDS, 32'h42, 4'd7, 1'b1, 1'b0, 1'b1), "inj idle");
        apply(r(1'b1, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b0, 1'b0, 1'b1), "inj rst");
        apply(r(1'b0, NUL, '0, 4'd0, 4'd0, '0, NUL, '0, 4'd0, 1'b1, 1'b0, 1'b0), "inj clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
